// File: rtl/rgb2hsv_seq_if.sv
// Pixel stream bundle around the RGB->HSV converter: one input channel, one output channel.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1; the
// sender holds data and valid stable until that edge, and ready never depends on valid.
interface rgb2hsv_seq_if;
    logic [23:0] tRGB;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] tHSV;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output tRGB, in_valid, out_ready,
        input  in_ready, tHSV, out_valid
    );

    modport slave (
        input  tRGB, in_valid, out_ready,
        output in_ready, tHSV, out_valid
    );
endinterface

// File: rtl/rgb2hsv_seq.sv
// Sequential RGB->HSV converter: one pixel in flight, a single shared 16-step restoring
// divider computes S and then H, giving a fixed 33-edge latency from accept to result.
module rgb2hsv_seq #(
    parameter int HUE_STEP = 43
) (
    input  logic           clk,
    input  logic           reset_n,
    rgb2hsv_seq_if.slave   px,
    output logic [2:0]     dbg_state_o
);
    typedef enum logic [2:0] {IDLE, PREP, DIV_S, DIV_H, DONE} state_t;

    localparam logic [7:0] BASE_G = 8'(2 * HUE_STEP - 1);
    localparam logic [7:0] BASE_B = 8'(4 * HUE_STEP - 1);

    state_t      state_q, state_d;
    logic [23:0] rgb_q, rgb_d;
    logic [7:0]  max_q, max_d;
    logic [7:0]  delta_q, delta_d;
    logic [1:0]  win_q, win_d;
    logic [8:0]  num_q, num_d;
    logic [7:0]  rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  s_q, s_d;
    logic [23:0] hsv_q, hsv_d;

    logic [7:0]  r, g, b, mx, mn;
    logic [1:0]  win;
    logic [8:0]  num, num_neg, rem_sh;
    logic [7:0]  num_abs, rem_step, base, h_raw;
    logic [15:0] quo_step;
    logic        ge;

    // Channel ordering on the captured pixel; ties resolve R over G over B.
    always_comb begin
        r = rgb_q[23:16];
        g = rgb_q[15:8];
        b = rgb_q[7:0];
        mx  = r;
        win = 2'd0;
        num = {1'b0, g} - {1'b0, b};
        if (g > mx) begin
            mx  = g;
            win = 2'd1;
            num = {1'b0, b} - {1'b0, r};
        end
        if (b > mx) begin
            mx  = b;
            win = 2'd2;
            num = {1'b0, r} - {1'b0, g};
        end
        mn = r;
        if (g < mn) mn = g;
        if (b < mn) mn = b;
    end

    // One restoring-division step: remainder is always below the divisor, so 8 bits hold it.
    always_comb begin
        rem_sh   = {rem_q, quo_q[15]};
        ge       = (rem_sh >= {1'b0, dvs_q});
        rem_step = ge ? 8'(rem_sh - {1'b0, dvs_q}) : rem_sh[7:0];
        quo_step = {quo_q[14:0], ge};
        num_neg  = ~num_q + 9'd1;
        num_abs  = num_q[8] ? num_neg[7:0] : num_q[7:0];
        case (win_q)
            2'd1:    base = BASE_G;
            2'd2:    base = BASE_B;
            default: base = 8'd0;
        endcase
        h_raw = num_q[8] ? (base - quo_step[7:0]) : (base + quo_step[7:0]);
    end

    always_comb begin
        state_d = state_q;
        rgb_d   = rgb_q;
        max_d   = max_q;
        delta_d = delta_q;
        win_d   = win_q;
        num_d   = num_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        hsv_d   = hsv_q;
        case (state_q)
            IDLE: begin
                if (px.in_valid) begin
                    rgb_d   = px.tRGB;
                    state_d = PREP;
                end
            end
            PREP: begin
                max_d   = mx;
                delta_d = mx - mn;
                win_d   = win;
                num_d   = num;
                rem_d   = 8'd0;
                quo_d   = {mx - mn, 8'd0} - {8'd0, mx - mn};
                dvs_d   = mx;
                cnt_d   = 4'd0;
                state_d = DIV_S;
            end
            DIV_S: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    // Guards only mask the result; the divider always runs its full 16 steps.
                    s_d     = (max_q == 8'd0) ? 8'd0 : quo_step[7:0];
                    rem_d   = 8'd0;
                    quo_d   = 16'(HUE_STEP) * {8'd0, num_abs};
                    dvs_d   = delta_q;
                    cnt_d   = 4'd0;
                    state_d = DIV_H;
                end
            end
            DIV_H: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    hsv_d   = {(delta_q == 8'd0) ? 8'd0 : h_raw, s_q, max_q};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (px.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rgb_q   <= '0;
            max_q   <= '0;
            delta_q <= '0;
            win_q   <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            hsv_q   <= '0;
        end else begin
            state_q <= state_d;
            rgb_q   <= rgb_d;
            max_q   <= max_d;
            delta_q <= delta_d;
            win_q   <= win_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            hsv_q   <= hsv_d;
        end
    end

    assign px.in_ready  = (state_q == IDLE);
    assign px.out_valid = (state_q == DONE);
    assign px.tHSV      = hsv_q;
    assign dbg_state_o  = state_q;
endmodule

// File: doc/rgb2hsv_seq.md
RGB2HSV_SEQ -- requirements
Module: rgb2hsv_seq

Interface
REQ-001 The block SHALL have one parameter: HUE_STEP, default 43, hue codes per 60-degree sector; sector bases SHALL be 0, 2*HUE_STEP-1 (85) and 4*HUE_STEP-1 (171).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port tRGB, input, 24 bits: pixel packed {R[23:16], G[15:8], B[7:0]}.
REQ-005 The block SHALL have port in_valid, input, 1 bit: tRGB is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a pixel.
REQ-007 The block SHALL have port tHSV, output, 24 bits: result packed {H[23:16], S[15:8], V[7:0]}, the packing used by the downstream hsv2rgb stage.
REQ-008 The block SHALL have port out_valid, output, 1 bit: tHSV holds a result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.

Function
REQ-010 The block SHALL implement the states IDLE, PREP, DIV_S, DIV_H and DONE.
REQ-011 in_ready SHALL be 1 only in IDLE; a pixel SHALL be accepted on a rising edge where IDLE and in_valid=1, and the block SHALL then capture tRGB and go to PREP.
REQ-012 PREP (1 cycle) SHALL register max=max(R,G,B), min=min(R,G,B) and delta=max-min (8-bit unsigned).
REQ-013 PREP SHALL register the winning channel with tie priority R over G over B, e.g. R=G=255 selects R.
REQ-014 PREP SHALL register the signed numerator: (G-B) if R wins, (B-R) if G wins, (R-G) if B wins, 9-bit two's complement.
REQ-015 DIV_S SHALL take exactly 16 cycles of one shared restoring divider: dividend 255*delta (16-bit), divisor max; quotient S SHALL be truncated to 8 bits.
REQ-016 DIV_H SHALL take exactly 16 cycles of the same divider: dividend HUE_STEP*|numerator| (16-bit), divisor delta, quotient truncated toward zero.
REQ-017 At the end of DIV_H, H SHALL equal base ± quotient, with the sign taken from the numerator, reduced modulo 256; e.g. base 0 minus 21 gives 235.
REQ-018 If max=0, S SHALL be forced to 0 and H to 0.
REQ-019 If delta=0, H SHALL be forced to 0.
REQ-020 For REQ-018 and REQ-019 the divider SHALL still run its full cycle count, so latency stays fixed.
REQ-021 V SHALL equal max.
REQ-022 The state SHALL move to DONE and out_valid SHALL rise exactly 33 rising edges after the accepting edge.
REQ-023 In DONE, tHSV and out_valid SHALL be held stable until an edge with out_ready=1; on that edge the state SHALL return to IDLE and out_valid SHALL fall.
REQ-024 in_valid SHALL be ignored in every state other than IDLE; tRGB changes after acceptance SHALL NOT affect the result.
REQ-025 Throughput SHALL be at most one pixel per 35 cycles (accept, 33, handshake); no buffering beyond one pixel in flight.
REQ-026 tHSV SHALL be registered, with no combinational path from tRGB or in_valid to any output.

Reset
REQ-027 When reset_n=0, regardless of clk, the block SHALL go to IDLE and set tHSV=24'h000000, out_valid=0 and in_ready=1.
REQ-028 Internal registers SHALL be cleared by reset_n=0.
REQ-029 Reset during PREP, DIV_S, DIV_H or DONE SHALL abandon the pixel in flight, which SHALL never be presented.
REQ-030 The first edge after reset_n rises SHALL be able to accept a pixel.

Verification
REQ-031 Reset: assert reset_n=0 mid-DIV_H -> same cycle out_valid=0, in_ready=1, tHSV=0; the abandoned pixel never appears.
REQ-032 tRGB=FF0000 -> tHSV=00FFFF with out_valid rising exactly 33 cycles after accept; tRGB=0000FF -> ABFFFF.
REQ-033 tRGB=FFFF00 (tie, R wins) -> 2BFFFF; tRGB=FF0080 (negative hue wrap) -> EBFFFF.
REQ-034 tRGB=808080 -> 000080; tRGB=000000 -> 000000 (both divide-by-zero guards), latency still 33.
REQ-035 Backpressure: out_ready=0 for 10 cycles after out_valid -> tHSV stable, in_ready=0, and an in_valid pulse in that window is not accepted; out_ready=1 -> out_valid falls next edge and in_ready=1.
REQ-036 Back-to-back: in_valid held high with 3 pixels and out_ready=1 -> 3 results in order, accepts spaced 35 cycles apart.
